// File: rtl/coeff_block_writer_if.sv
// Coefficient stream and SRAM write bus for the pre-IDCT coefficient writer.
// The slave modport is the writer's view; the master modport is the view of
// the producer/SRAM side that drives coefficients and observes writes.
interface coeff_block_writer_if;
   logic        coeff_valid;
   logic [15:0] coeff_data;
   logic        coeff_ready;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;

   modport master (
      output coeff_valid,
      output coeff_data,
      input  coeff_ready,
      input  SRAM_address,
      input  SRAM_write_data,
      input  SRAM_we_n
   );

   modport slave (
      input  coeff_valid,
      input  coeff_data,
      output coeff_ready,
      output SRAM_address,
      output SRAM_write_data,
      output SRAM_we_n
   );
endinterface

// File: rtl/coeff_block_writer.sv
// Pre-IDCT coefficient writer: accepts dequantized coefficients in zigzag
// order, one 8x8 block at a time, and writes each to its raster position in
// SRAM. Blocks are walked left-to-right, top-to-bottom, for Y then U then V.
module coeff_block_writer #(
   parameter int PRE_IDCT_BASE = 76800,
   parameter int Y_WIDTH       = 320,
   parameter int UV_WIDTH      = 160,
   parameter int ROW_BLOCKS    = 30
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   coeff_block_writer_if.slave   bus,
   output logic                  block_done,
   output logic                  busy,
   output logic                  finish
);

   localparam logic [17:0] Y_BASE   = 18'(PRE_IDCT_BASE);
   localparam logic [17:0] U_BASE   = 18'(PRE_IDCT_BASE + Y_WIDTH * ROW_BLOCKS * 8);
   localparam logic [17:0] V_BASE   = 18'(PRE_IDCT_BASE + Y_WIDTH * ROW_BLOCKS * 8
                                          + UV_WIDTH * ROW_BLOCKS * 8);
   localparam logic [17:0] Y_W      = 18'(Y_WIDTH);
   localparam logic [17:0] UV_W     = 18'(UV_WIDTH);
   localparam logic [5:0]  Y_LAST   = 6'(Y_WIDTH / 8 - 1);
   localparam logic [5:0]  UV_LAST  = 6'(UV_WIDTH / 8 - 1);
   localparam logic [4:0]  ROW_LAST = 5'(ROW_BLOCKS - 1);

   // Zigzag index k -> raster index r*8+c within the block (standard JPEG order).
   localparam logic [5:0] ZIGZAG [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DRAIN
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [5:0]  k;
   logic [5:0]  col_block;
   logic [4:0]  row_block;
   logic [1:0]  seg;

   logic        accept;
   logic        start_ok;
   logic        last_k;
   logic        last_col;
   logic        last_row;
   logic        last_seg;
   logic        image_last;
   logic [5:0]  zz;
   logic [7:0]  pix_row;
   logic [17:0] seg_base;
   logic [17:0] plane_w;
   logic [17:0] addr_next;

   // Handshake and end-of-image decode from the current counters.
   always_comb begin
      accept     = bus.coeff_valid && bus.coeff_ready;
      // finish is still high in the first IDLE cycle; a start there is dropped.
      start_ok   = start && (state == IDLE) && !finish;
      last_k     = (k == 6'd63);
      last_col   = (col_block == ((seg == 2'd0) ? Y_LAST : UV_LAST));
      last_row   = (row_block == ROW_LAST);
      last_seg   = (seg == 2'd2);
      image_last = accept && last_k && last_col && last_row && last_seg;
   end

   // Raster address of the coefficient currently offered.
   always_comb begin
      zz      = ZIGZAG[k];
      pix_row = {row_block, zz[5:3]};
      case (seg)
         2'd0:    begin seg_base = Y_BASE; plane_w = Y_W;  end
         2'd1:    begin seg_base = U_BASE; plane_w = UV_W; end
         default: begin seg_base = V_BASE; plane_w = UV_W; end
      endcase
      // Constant-width multiply; reduces to shift-adds (256+64, 128+32).
      addr_next = seg_base + 18'(pix_row) * plane_w + 18'({col_block, zz[2:0]});
   end

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      next_state      = state;
      bus.coeff_ready = 1'b0;
      busy            = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) next_state = WRITE;
         end
         WRITE: begin
            bus.coeff_ready = 1'b1;
            busy            = 1'b1;
            if (image_last) next_state = DRAIN;
         end
         DRAIN: begin
            busy       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Block/segment counters and the registered SRAM write port.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         k                   <= '0;
         col_block           <= '0;
         row_block           <= '0;
         seg                 <= '0;
         block_done          <= 1'b0;
         finish              <= 1'b0;
         bus.SRAM_we_n       <= 1'b1;
         bus.SRAM_address    <= '0;
         bus.SRAM_write_data <= '0;
      end else begin
         block_done    <= accept && last_k;
         finish        <= (state == DRAIN);
         bus.SRAM_we_n <= !accept;
         if (start_ok) begin
            k         <= '0;
            col_block <= '0;
            row_block <= '0;
            seg       <= '0;
         end else if (accept) begin
            bus.SRAM_address    <= addr_next;
            bus.SRAM_write_data <= bus.coeff_data;
            k                   <= k + 6'd1;
            if (last_k) begin
               if (last_col) begin
                  col_block <= '0;
                  if (last_row) begin
                     row_block <= '0;
                     seg       <= last_seg ? 2'd0 : seg + 2'd1;
                  end else begin
                     row_block <= row_block + 5'd1;
                  end
               end else begin
                  col_block <= col_block + 6'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_coeff_block_writer.sv
// Bench for coeff_block_writer: a full-size instance for directed address
// points, gaps and mid-image reset, and a 3-block-row instance for a complete
// Y/U/V image. Expected writes come from a zigzag/raster reference model.
module tb_coeff_block_writer;

   logic clock;
   logic resetn;
   logic start_a, start_b;
   logic done_a, done_b;
   logic busy_a, busy_b;
   logic fin_a, fin_b;

   coeff_block_writer_if bus_a ();
   coeff_block_writer_if bus_b ();

   coeff_block_writer dut_a (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start_a),
      .bus        (bus_a),
      .block_done (done_a),
      .busy       (busy_a),
      .finish     (fin_a)
   );

   coeff_block_writer #(.ROW_BLOCKS(3)) dut_b (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start_b),
      .bus        (bus_b),
      .block_done (done_b),
      .busy       (busy_b),
      .finish     (fin_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference model state, one slot per instance.
   int p_base [2] = '{76800, 76800};
   int p_yw   [2] = '{320, 320};
   int p_uvw  [2] = '{160, 160};
   int p_rows [2] = '{30, 3};
   int zr [64];
   int zc [64];
   bit m_busy  [2];
   bit m_drain [2];
   bit m_fin   [2];
   int m_n     [2];
   logic [17:0] e_addr [2];
   logic [15:0] e_data [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Build zigzag order by walking anti-diagonals, alternating direction.
   function automatic void build_zigzag();
      int idx = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zr[idx] = r; zc[idx] = s - r; idx++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zr[idx] = r; zc[idx] = s - r; idx++; end
         end
      end
   endfunction

   function automatic int total_of(int sel);
      return (p_yw[sel] / 8 + 2 * (p_uvw[sel] / 8)) * p_rows[sel] * 64;
   endfunction

   // Address of the n-th coefficient of an image.
   function automatic int addr_of(int sel, int n);
      int blk = n / 64;
      int k = n % 64;
      int yb = (p_yw[sel] / 8) * p_rows[sel];
      int ub = (p_uvw[sel] / 8) * p_rows[sel];
      int base, w, b;
      if (blk < yb) begin
         base = p_base[sel]; w = p_yw[sel]; b = blk;
      end else if (blk < yb + ub) begin
         base = p_base[sel] + p_yw[sel] * p_rows[sel] * 8; w = p_uvw[sel]; b = blk - yb;
      end else begin
         base = p_base[sel] + (p_yw[sel] + p_uvw[sel]) * p_rows[sel] * 8;
         w = p_uvw[sel]; b = blk - yb - ub;
      end
      return base + ((b / (w / 8)) * 8 + zr[k]) * w + (b % (w / 8)) * 8 + zc[k];
   endfunction

   // Hand-computed anchor addresses for selected coefficient indices.
   function automatic int lit_addr(int sel, int n);
      if (sel == 0) begin
         case (n)
            0:    return 76800;
            1:    return 76801;
            2:    return 77120;
            63:   return 79047;
            64:   return 76808;
            2560: return 79360;
            default: return -1;
         endcase
      end else begin
         case (n)
            7680:  return 84480;
            7682:  return 84640;
            11520: return 88320;
            15359: return 92159;
            default: return -1;
         endcase
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 2; s++) begin
         m_busy[s] = 0; m_drain[s] = 0; m_fin[s] = 0; m_n[s] = 0;
         e_addr[s] = '0; e_data[s] = '0;
      end
   endfunction

   task automatic check_reset_vals(input int sel);
      if (sel == 0) begin
         check("rst_ready", 32'(bus_a.coeff_ready), 0);
         check("rst_done", 32'(done_a), 0);
         check("rst_busy", 32'(busy_a), 0);
         check("rst_finish", 32'(fin_a), 0);
         check("rst_we_n", 32'(bus_a.SRAM_we_n), 1);
         check("rst_addr", 32'(bus_a.SRAM_address), 0);
         check("rst_data", 32'(bus_a.SRAM_write_data), 0);
      end else begin
         check("rst_b_busy", 32'(busy_b), 0);
         check("rst_b_we_n", 32'(bus_b.SRAM_we_n), 1);
         check("rst_b_addr", 32'(bus_b.SRAM_address), 0);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      bus_a.coeff_valid = 1'b0; bus_b.coeff_valid = 1'b0;
      #1;
      check_reset_vals(0);
      check_reset_vals(1);
      model_reset();
      @(posedge clock); #1;
      resetn = 1'b1;
   endtask

   // One clock cycle on instance sel: drive, check ready, clock, check outputs.
   task automatic cycle(input int sel, input logic v, input logic [15:0] d, input logic st);
      bit exp_rdy, acc, fin_new, start_ok, exp_done;
      bit exp_we;
      int lit;
      start_a = (sel == 0) && st;
      start_b = (sel == 1) && st;
      bus_a.coeff_valid = (sel == 0) && v;
      bus_b.coeff_valid = (sel == 1) && v;
      bus_a.coeff_data  = d;
      bus_b.coeff_data  = d;
      exp_rdy = m_busy[sel] && !m_drain[sel];
      check("ready", 32'(sel == 0 ? bus_a.coeff_ready : bus_b.coeff_ready), 32'(exp_rdy));
      @(posedge clock); #1;
      acc      = v && exp_rdy;
      fin_new  = m_drain[sel];
      start_ok = st && !m_busy[sel] && !m_fin[sel];
      if (m_drain[sel]) begin m_busy[sel] = 0; m_drain[sel] = 0; end
      exp_we = 1; exp_done = 0; lit = -1;
      if (acc) begin
         exp_we = 0;
         e_addr[sel] = 18'(addr_of(sel, m_n[sel]));
         e_data[sel] = d;
         exp_done = (m_n[sel] % 64 == 63);
         lit = lit_addr(sel, m_n[sel]);
         m_n[sel]++;
         if (m_n[sel] == total_of(sel)) m_drain[sel] = 1;
      end
      if (start_ok) begin m_busy[sel] = 1; m_n[sel] = 0; end
      m_fin[sel] = fin_new;
      if (sel == 0) begin
         check("we_n", 32'(bus_a.SRAM_we_n), 32'(exp_we));
         check("addr", 32'(bus_a.SRAM_address), 32'(e_addr[0]));
         check("data", 32'(bus_a.SRAM_write_data), 32'(e_data[0]));
         check("block_done", 32'(done_a), 32'(exp_done));
         check("busy", 32'(busy_a), 32'(m_busy[0]));
         check("finish", 32'(fin_a), 32'(m_fin[0]));
         if (lit >= 0) check("anchor_addr", 32'(bus_a.SRAM_address), 32'(lit));
      end else begin
         check("b_we_n", 32'(bus_b.SRAM_we_n), 32'(exp_we));
         check("b_addr", 32'(bus_b.SRAM_address), 32'(e_addr[1]));
         check("b_data", 32'(bus_b.SRAM_write_data), 32'(e_data[1]));
         check("b_block_done", 32'(done_b), 32'(exp_done));
         check("b_busy", 32'(busy_b), 32'(m_busy[1]));
         check("b_finish", 32'(fin_b), 32'(m_fin[1]));
         if (lit >= 0) check("b_anchor_addr", 32'(bus_b.SRAM_address), 32'(lit));
      end
   endtask

   initial begin
      int guard;
      build_zigzag();
      model_reset();
      resetn = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      bus_a.coeff_valid = 1'b0; bus_a.coeff_data = '0;
      bus_b.coeff_valid = 1'b0; bus_b.coeff_data = '0;
      repeat (2) @(posedge clock);
      #1;
      check_reset_vals(0);
      check_reset_vals(1);
      resetn = 1'b1;
      cycle(0, 1'b0, 16'd0, 1'b0);

      // First block with data=k, then on through block row 1, continuous valid.
      cycle(0, 1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 2624; i++)
         cycle(0, 1'b1, (m_n[0] < 64) ? 16'(m_n[0]) : 16'($urandom_range(0, 65535)), 1'b0);
      repeat (3) cycle(0, 1'b0, 16'd0, 1'b0);
      do_reset();

      // Block 0 again with ~30% valid gaps.
      cycle(0, 1'b0, 16'd0, 1'b1);
      guard = 0;
      while (m_n[0] < 64 && guard < 1000) begin
         cycle(0, ($urandom_range(0, 99) >= 30), 16'(m_n[0]), 1'b0);
         guard++;
      end
      check("gap_progress", 32'(m_n[0]), 64);
      repeat (3) cycle(0, 1'b0, 16'd0, 1'b0);
      do_reset();

      // Reset after 100 accepts, then a clean restart.
      cycle(0, 1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 100; i++) cycle(0, 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
      do_reset();
      repeat (4) cycle(0, 1'b0, 16'd0, 1'b0);
      cycle(0, 1'b0, 16'd0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(0, 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
      repeat (2) cycle(0, 1'b0, 16'd0, 1'b0);

      // Whole image on the reduced instance, with gaps and stray starts.
      cycle(1, 1'b0, 16'd0, 1'b1);
      guard = 0;
      while (m_busy[1] && !m_drain[1] && guard < 40000) begin
         cycle(1, ($urandom_range(0, 99) >= 10), 16'($urandom_range(0, 65535)),
               ($urandom_range(0, 99) < 3));
         guard++;
      end
      check("image_complete", 32'(m_n[1]), 32'(total_of(1)));
      cycle(1, 1'b0, 16'd0, 1'b1);
      cycle(1, 1'b0, 16'd0, 1'b1);
      repeat (3) cycle(1, 1'b0, 16'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
